booth_mult_sched: RTL and testbench

BOOTH_MULT_SCHED -- requirements
Module: booth_mult_sched

---
 rtl/booth_mult_sched_if.sv | 52 +++++
 rtl/booth_mult_sched.sv | 160 ++++++++++++++++
 tb/tb_booth_mult_sched.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mult_sched_if.sv
// booth_mult_sched_if
//   Bundles the request, response and Booth-core buses of booth_mult_sched.
//   Parameters:
//     NB    log2 of the operand width
//     N     operand width in bits (products are 2*N bits)
//     NREQ  number of requesters (fixed at 4, ids are 2 bits)
//   Signals:
//     req_valid/req_m/req_q  per-requester request and packed operands
//     req_ready              one-hot accept strobe back to the requesters
//     resp_valid/resp_ready  result handshake
//     resp_id/resp_p/resp_err  owner id, signed product, watchdog flag
//     mul_load/mul_m/mul_q   control and operands to the shared Booth core
//     mul_done/mul_p         completion pulse and product from the core
//   Modports:
//     slave   the scheduler's view
//     master  the environment's view (requesters, consumer and core)
interface booth_mult_sched_if #(
  parameter int NB   = 2,
  parameter int N    = 2**NB,
  parameter int NREQ = 4
);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_m;
  logic [NREQ*N-1:0] req_q;
  logic [NREQ-1:0]   req_ready;

  logic              resp_valid;
  logic              resp_ready;
  logic [1:0]        resp_id;
  logic [2*N-1:0]    resp_p;
  logic              resp_err;

  logic              mul_load;
  logic [N-1:0]      mul_m;
  logic [N-1:0]      mul_q;
  logic              mul_done;
  logic [2*N-1:0]    mul_p;

  modport slave (
    input  req_valid, req_m, req_q, resp_ready, mul_done, mul_p,
    output req_ready, resp_valid, resp_id, resp_p, resp_err,
           mul_load, mul_m, mul_q
  );

  modport master (
    output req_valid, req_m, req_q, resp_ready, mul_done, mul_p,
    input  req_ready, resp_valid, resp_id, resp_p, resp_err,
           mul_load, mul_m, mul_q
  );

endinterface

// File: rtl/booth_mult_sched.sv
// booth_mult_sched
//   Round-robin scheduler that shares one sequential Booth multiplier core
//   among four requesters. One transaction is in flight at a time: a request
//   is granted in IDLE, its operands are loaded into the core in LOAD, the
//   core iterates in RUN, and the product is held in RESP until the consumer
//   takes it. A watchdog in RUN substitutes an error result if the core never
//   reports completion.
//   Ports:
//     clk   clock, all state changes on the rising edge
//     rst   synchronous active-low reset
//     bus   booth_mult_sched_if.slave (request, response and core buses)
//     busy  high whenever the scheduler is not idle
module booth_mult_sched #(
  parameter int NB   = 2,
  parameter int N    = 2**NB,
  parameter int NREQ = 4
) (
  input  logic                clk,
  input  logic                rst,
  booth_mult_sched_if.slave   bus,
  output logic                busy
);

  // The core normally finishes in the (N+1)th RUN cycle; the watchdog gives
  // it until the (N+4)th RUN cycle before forcing an error result.
  localparam int WDLIM = N + 3;
  localparam int WDW   = $clog2(WDLIM + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    RESP
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [1:0]      rr;
  logic [1:0]      id_r;
  logic [N-1:0]    m_r;
  logic [N-1:0]    q_r;
  logic [WDW-1:0]  wd;
  logic [2*N-1:0]  p_r;
  logic            err_r;

  logic            grant_found;
  logic [1:0]      grant_idx;
  logic [1:0]      cand;
  logic [NREQ-1:0] ready;
  logic            wd_expired;

  // Search upward from the round-robin pointer; the 2-bit index wraps
  // naturally, which is the modulo-4 search over the requesters.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = rr + 2'(k);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign wd_expired = (wd == WDW'(WDLIM));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The accept strobe is withheld while reset is asserted so that no
  // requester sees a handshake the scheduler is about to discard.
  always_comb begin
    state_nxt = state;
    ready     = '0;
    case (state)
      IDLE: begin
        if (grant_found && rst) begin
          ready[grant_idx] = 1'b1;
          state_nxt        = LOAD;
        end
      end
      LOAD: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (bus.mul_done || wd_expired) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // A completion pulse wins over the watchdog if both land in the last
  // allowed RUN cycle. mul_done outside RUN never touches the result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr    <= '0;
      id_r  <= '0;
      m_r   <= '0;
      q_r   <= '0;
      wd    <= '0;
      p_r   <= '0;
      err_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            id_r <= grant_idx;
            m_r  <= bus.req_m[grant_idx*N +: N];
            q_r  <= bus.req_q[grant_idx*N +: N];
            rr   <= grant_idx + 2'd1;
          end
        end
        LOAD: begin
          wd <= '0;
        end
        RUN: begin
          if (bus.mul_done) begin
            p_r   <= bus.mul_p;
            err_r <= 1'b0;
          end else if (wd_expired) begin
            p_r   <= '0;
            err_r <= 1'b1;
          end else begin
            wd <= wd + WDW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_p     = p_r;
  assign bus.resp_id    = id_r;
  assign bus.resp_err   = err_r;
  assign bus.mul_load   = (state != RUN);
  assign bus.mul_m      = m_r;
  assign bus.mul_q      = q_r;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_booth_mult_sched.sv
// tb_booth_mult_sched
//   Self-checking bench for booth_mult_sched. A behavioural Booth core answers
//   the scheduler with a configurable latency (or not at all), and a
//   transaction-level model predicts every output each cycle from the
//   arbitration rule, the accept-to-response timing and signed arithmetic.
//   Directed scenarios pin known products, grant order, response holding,
//   the watchdog and mid-run reset; a randomized phase follows.
module tb_booth_mult_sched;

  localparam int NB   = 2;
  localparam int N    = 4;
  localparam int NREQ = 4;
  localparam int W    = 2 * N;

  logic clk;
  logic rst;
  logic busy;

  booth_mult_sched_if #(.NB(NB), .N(N), .NREQ(NREQ)) bus ();

  booth_mult_sched #(.NB(NB), .N(N), .NREQ(NREQ)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  int checks;
  int errors;

  // behavioural core: loads while mul_load is high, counts while it is low
  int           core_lat;
  int           core_cnt;
  logic         spur;
  logic         core_fire;
  logic [N-1:0] core_m;
  logic [N-1:0] core_q;

  // snapshots of the DUT taken mid-cycle
  logic [NREQ-1:0] s_req_ready;
  logic            s_resp_valid;
  logic [W-1:0]    s_resp_p;
  logic [1:0]      s_resp_id;
  logic            s_resp_err;
  logic            s_busy;
  logic            s_mul_load;

  // transaction-level model
  logic         m_valid;
  logic         m_busy;
  logic         m_clean;
  int           m_age;
  int           m_rr;
  int           m_id;
  logic [N-1:0] m_m;
  logic [N-1:0] m_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] prod_model(input logic [N-1:0] a, input logic [N-1:0] b);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    logic signed [W-1:0] pr;
    sa = {{N{a[N-1]}}, a};
    sb = {{N{b[N-1]}}, b};
    pr = sa * sb;
    return pr;
  endfunction

  always @(posedge clk) begin
    if (bus.mul_load) begin
      core_m   <= bus.mul_m;
      core_q   <= bus.mul_q;
      core_cnt <= 0;
    end else begin
      core_cnt <= core_cnt + 1;
    end
  end

  always_comb begin
    core_fire    = !bus.mul_load && (core_cnt == core_lat);
    bus.mul_done = core_fire | spur;
    bus.mul_p    = core_fire ? prod_model(core_m, core_q) : ({core_m, core_q} ^ 8'h5A);
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input int id,
                               input logic [N-1:0] m, input logic [N-1:0] q);
    bus.req_m[id*N +: N] = m;
    bus.req_q[id*N +: N] = q;
    bus.req_valid        = valid;
  endtask

  // Compare the DUT against the model for the current cycle, then advance
  // the model by the edge that ends it.
  task automatic model_step();
    int              resp_age;
    logic            exp_err;
    logic [W-1:0]    exp_p;
    logic            found;
    int              g;
    int              c;
    logic [NREQ-1:0] exp_ready;
    logic            in_resp;

    s_req_ready  = bus.req_ready;
    s_resp_valid = bus.resp_valid;
    s_resp_p     = bus.resp_p;
    s_resp_id    = bus.resp_id;
    s_resp_err   = bus.resp_err;
    s_busy       = busy;
    s_mul_load   = bus.mul_load;

    // age 0 is the accept cycle, age 1 the load cycle, RUN cycle k is age k+1
    resp_age = (core_lat <= N + 3) ? core_lat + 3 : N + 6;
    exp_err  = (core_lat > N + 3);

    found = 1'b0;
    g     = 0;
    for (int k = 0; k < NREQ; k++) begin
      c = (m_rr + k) % NREQ;
      if (!found && bus.req_valid[c]) begin
        found = 1'b1;
        g     = c;
      end
    end

    if (m_valid) begin
      if (!m_busy) begin
        exp_ready = '0;
        if (found && rst) exp_ready[g] = 1'b1;
        checkOutput("idle_req_ready", 64'(s_req_ready), 64'(exp_ready));
        checkOutput("idle_busy", 64'(s_busy), 64'(0));
        checkOutput("idle_resp_valid", 64'(s_resp_valid), 64'(0));
        checkOutput("idle_mul_load", 64'(s_mul_load), 64'(1));
        if (m_clean) begin
          checkOutput("rst_resp_p", 64'(s_resp_p), 64'(0));
          checkOutput("rst_resp_id", 64'(s_resp_id), 64'(0));
          checkOutput("rst_resp_err", 64'(s_resp_err), 64'(0));
          checkOutput("rst_mul_m", 64'(bus.mul_m), 64'(0));
          checkOutput("rst_mul_q", 64'(bus.mul_q), 64'(0));
        end
      end else begin
        in_resp = (m_age >= resp_age);
        checkOutput("act_req_ready", 64'(s_req_ready), 64'(0));
        checkOutput("act_busy", 64'(s_busy), 64'(1));
        checkOutput("act_resp_valid", 64'(s_resp_valid), 64'(in_resp));
        checkOutput("act_mul_load", 64'(s_mul_load), 64'(!(m_age >= 2 && !in_resp)));
        if (m_age == 1) begin
          checkOutput("load_mul_m", 64'(bus.mul_m), 64'(m_m));
          checkOutput("load_mul_q", 64'(bus.mul_q), 64'(m_q));
        end
        if (in_resp) begin
          exp_p = exp_err ? '0 : prod_model(m_m, m_q);
          checkOutput("resp_p", 64'(s_resp_p), 64'(exp_p));
          checkOutput("resp_id", 64'(s_resp_id), 64'(m_id));
          checkOutput("resp_err", 64'(s_resp_err), 64'(exp_err));
        end
      end
    end

    if (!rst) begin
      m_valid = 1'b1;
      m_busy  = 1'b0;
      m_clean = 1'b1;
      m_rr    = 0;
      m_age   = 0;
    end else if (m_valid) begin
      if (!m_busy) begin
        if (found) begin
          m_busy  = 1'b1;
          m_clean = 1'b0;
          m_age   = 1;
          m_id    = g;
          m_m     = bus.req_m[g*N +: N];
          m_q     = bus.req_q[g*N +: N];
          m_rr    = (g + 1) % NREQ;
        end
      end else if (m_age >= resp_age) begin
        if (bus.resp_ready) m_busy = 1'b0;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from requester id, drop it once granted, and return
  // the grant strobe, the response fields and the accept-to-response latency.
  task automatic runTxn(input int id, input logic [N-1:0] m, input logic [N-1:0] q,
                        output logic [NREQ-1:0] gnt, output logic [W-1:0] p,
                        output logic [1:0] rid, output logic err, output int lat);
    int              k;
    logic [NREQ-1:0] sel;
    sel     = '0;
    sel[id] = 1'b1;
    applyStimulus(sel, id, m, q);
    k = 0;
    do begin
      cycle();
      k++;
    end while (s_req_ready == '0 && k < 50);
    gnt = s_req_ready;
    checkOutput("grant_seen", 64'(gnt != '0), 64'(1));
    bus.req_valid = '0;
    lat = 0;
    do begin
      cycle();
      lat++;
    end while (!s_resp_valid && lat < 40);
    checkOutput("resp_seen", 64'(s_resp_valid), 64'(1));
    p   = s_resp_p;
    rid = s_resp_id;
    err = s_resp_err;
  endtask

  initial begin
    logic [NREQ-1:0] gnt;
    logic [W-1:0]    p;
    logic [1:0]      rid;
    logic            err;
    logic [3:0]      one;
    int              lat;
    int              k;

    checks        = 0;
    errors        = 0;
    m_valid       = 1'b0;
    m_busy        = 1'b0;
    m_clean       = 1'b0;
    m_age         = 0;
    m_rr          = 0;
    m_id          = 0;
    m_m           = '0;
    m_q           = '0;
    rst           = 1'b0;
    spur          = 1'b0;
    core_lat      = N;
    bus.req_valid = '0;
    bus.req_m     = '0;
    bus.req_q     = '0;
    bus.resp_ready = 1'b1;
    one           = 4'b0001;

    @(posedge clk);
    #1;
    repeat (3) cycle();
    rst = 1'b1;
    cycle();

    $display("[TB] pinning the product model");
    checkOutput("model_3xm2", 64'(prod_model(4'd3, 4'hE)), 64'(8'hFA));
    checkOutput("model_m8xm8", 64'(prod_model(4'h8, 4'h8)), 64'(8'h40));
    checkOutput("model_7xm8", 64'(prod_model(4'd7, 4'h8)), 64'(8'hC8));

    $display("[TB] single request from requester 1");
    runTxn(1, 4'd3, 4'hE, gnt, p, rid, err, lat);
    checkOutput("t1_grant", 64'(gnt), 64'(4'b0010));
    checkOutput("t1_latency", 64'(lat), 64'(7));
    checkOutput("t1_p", 64'(p), 64'(8'hFA));
    checkOutput("t1_id", 64'(rid), 64'(1));
    checkOutput("t1_err", 64'(err), 64'(0));

    $display("[TB] round-robin order with all requesters held");
    rst = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_m[i*N +: N] = N'($urandom);
      bus.req_q[i*N +: N] = N'($urandom);
    end
    bus.req_valid = 4'hF;
    for (int t = 0; t < 5; t++) begin
      k = 0;
      do begin
        cycle();
        k++;
      end while (s_req_ready == '0 && k < 40);
      checkOutput("grant_order", 64'(s_req_ready), 64'(one << (t % 4)));
    end
    bus.req_valid = '0;

    $display("[TB] signed corner products");
    runTxn(0, 4'h8, 4'h8, gnt, p, rid, err, lat);
    checkOutput("t3a_p", 64'(p), 64'(8'h40));
    runTxn(3, 4'd7, 4'h8, gnt, p, rid, err, lat);
    checkOutput("t3b_p", 64'(p), 64'(8'hC8));
    checkOutput("t3b_id", 64'(rid), 64'(3));

    $display("[TB] response held under back-pressure");
    bus.resp_ready = 1'b0;
    runTxn(2, 4'd5, 4'd3, gnt, p, rid, err, lat);
    checkOutput("t4_p", 64'(p), 64'(8'h0F));
    bus.req_valid = 4'hF;
    spur = 1'b1;
    for (int t = 0; t < 10; t++) begin
      cycle();
      checkOutput("hold_valid", 64'(s_resp_valid), 64'(1));
      checkOutput("hold_p", 64'(s_resp_p), 64'(8'h0F));
      checkOutput("hold_id", 64'(s_resp_id), 64'(2));
      checkOutput("hold_req_ready", 64'(s_req_ready), 64'(0));
      checkOutput("hold_busy", 64'(s_busy), 64'(1));
    end
    bus.resp_ready = 1'b1;
    bus.req_valid  = '0;
    spur           = 1'b0;
    cycle();

    $display("[TB] watchdog with a silent core");
    core_lat = 1000;
    runTxn(3, 4'd6, 4'd2, gnt, p, rid, err, lat);
    checkOutput("wd_err", 64'(err), 64'(1));
    checkOutput("wd_p", 64'(p), 64'(0));
    checkOutput("wd_latency", 64'(lat), 64'(N + 6));
    core_lat = N;

    $display("[TB] reset in the third RUN cycle");
    applyStimulus(4'b0100, 2, 4'd5, 4'd6);
    k = 0;
    do begin
      cycle();
      k++;
    end while (s_req_ready == '0 && k < 40);
    checkOutput("t6_grant", 64'(s_req_ready), 64'(4'b0100));
    bus.req_valid = '0;
    cycle();
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    checkOutput("t6_busy", 64'(s_busy), 64'(0));
    checkOutput("t6_mul_load", 64'(s_mul_load), 64'(1));
    for (int t = 0; t < 15; t++) begin
      cycle();
      checkOutput("t6_no_resp", 64'(s_resp_valid), 64'(0));
    end
    runTxn(2, 4'd5, 4'd6, gnt, p, rid, err, lat);
    checkOutput("t6_retry_p", 64'(p), 64'(8'h1E));
    checkOutput("t6_retry_lat", 64'(lat), 64'(7));
    checkOutput("t6_retry_id", 64'(rid), 64'(2));

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      logic [NREQ-1:0] acc;
      acc = bus.req_valid & s_req_ready;
      if (acc != '0) begin
        core_lat = ($urandom_range(0, 7) == 0) ? 100 : N + int'($urandom_range(0, 3));
      end
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] || !bus.req_valid[i]) begin
          bus.req_valid[i]    = ($urandom_range(0, 2) != 0);
          bus.req_m[i*N +: N] = N'($urandom);
          bus.req_q[i*N +: N] = N'($urandom);
        end
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      rst            = ($urandom_range(0, 299) != 0);
      cycle();
    end
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.resp_ready = 1'b1;
    repeat (20) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
